mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single instruction/data memory port between the IF stage (instruction fetch, read-only) and the MEM stage (loads/stores) of the RISC-V pipeline. It is a registered request/ack arbiter with a four-state FSM. MEM has priority, and a starvation limit guarantees IF forward progress. An IF flush (jump/branch purge) discards an in-flight fetch without corrupting the memory handshake.

## Interface
- ADDR_L, 32, address width
- DATA_L, 32, data width
- STARVE_LIM, 4, consecutive MEM grants allowed while IF waits (1..7)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- if_re  in  1  IF read request, level, held until if_ack or if_flush
- if_addr  in  ADDR_L  fetch address
- if_flush  in  1  one-cycle purge of the pending/in-flight fetch
- if_ack  out  1  one-cycle pulse; if_rdata valid
- if_rdata  out  DATA_L  fetched instruction
- mem_re / mem_we  in  1  MEM read/write request, level, held until mem_ack
- mem_addr  in  ADDR_L  load/store address
- mem_len  in  2  access length: 0 byte, 1 half, 3 word
- mem_wdata  in  DATA_L  store data
- mem_ack  out  1  one-cycle pulse; mem_rdata valid on loads
- mem_rdata  out  DATA_L  load data
- m_re / m_we  out  1  memory read/write strobe, held until m_ack
- m_addr  out  ADDR_L, m_len out 2, m_wdata out DATA_L  transaction fields, stable while strobe high
- m_ack  in  1  memory completion pulse; m_rdata valid same cycle
- m_rdata  in  DATA_L  memory read data

## Operation
- States: IDLE, GRANT_IF, GRANT_MEM, DRAIN.
- IDLE: candidates are if_re && !if_flush && !if_ack, and (mem_re||mem_we) && !mem_ack. Masking with the requester's own ack prevents re-granting a request that is still high in its ack cycle.
- Priority: MEM wins. The exception is when starve_cnt == STARVE_LIM and IF is a candidate; IF then wins.
- Granting latches the address, length, data and direction into m_* and raises m_re or m_we. IF always uses m_len = 3 and m_re.
- mem_re && mem_we together is illegal. It is treated as a write, and a simulation $display warning is issued.
- GRANT_IF:
  - on m_ack, register if_rdata, pulse if_ack and return to IDLE.
  - on if_flush without m_ack, go to DRAIN.
  - if_flush and m_ack in the same cycle: result discarded, no if_ack, go to IDLE.
- GRANT_MEM: on m_ack, register mem_rdata (loads), pulse mem_ack and return to IDLE. if_flush does not affect MEM.
- DRAIN: keep the strobe until m_ack, drop the data, return to IDLE, no ack.
- starve_cnt (3 bits):
  - increments on each MEM grant while if_re is high;
  - clears on an IF grant, or when if_re is low in IDLE;
  - saturates at STARVE_LIM.

## Timing
- Reset: state IDLE, starve_cnt 0, every output 0 (if_ack, if_rdata, mem_ack, mem_rdata, m_re, m_we, m_addr, m_len, m_wdata).
- Request sampled at edge E. The strobe is high from E. Memory may ack no earlier than the cycle after the strobe rises. Requester ack is registered, one cycle after m_ack.
- Minimum round trip: request in cycle 0, strobe in cycle 1, m_ack in cycle 2, ack in cycle 3.
- The arbiter is in IDLE during the ack cycle. A new grant can start at the end of that cycle, so back-to-back transactions are spaced 3 cycles apart minimum.
- Strobes stay continuously high from grant to m_ack. m_* fields are constant over that interval.
- A requester must drop its request, or present a new one, by the edge after its ack.
- if_flush in the same cycle as an IDLE grant decision suppresses the IF grant; MEM may still be granted.
- Reset mid-transaction abandons the transaction. The memory model shares rst and must abort too.

## Structure
- State encodings and the length codes (LEN_B=0, LEN_H=1, LEN_W=3) go in riscv_const.v alongside the OP_* constants.
- Single module, no sub-module. The starvation counter is inline.

## Test plan
- Lone IF fetch at 0x1000, memory ack one cycle after strobe, returns 0x00000013 -> m_re in cycle 1, if_ack with if_rdata=0x00000013 in cycle 3, no second grant.
- if_re and mem_re asserted together, loads at 0x2000 -> MEM granted first, IF granted at the end of mem_ack's cycle.
- MEM issues 10 back-to-back stores while if_re is held, STARVE_LIM=4 -> IF granted after exactly 4 MEM grants, starve_cnt returns to 0.
- if_flush while GRANT_IF with memory latency 5 -> DRAIN, m_re held until m_ack, no if_ack, next IF request at 0x3000 served correctly.
- if_flush and m_ack in the same cycle; separately, rst asserted mid GRANT_MEM -> no if_ack; after reset all outputs are 0 and the FSM is in IDLE.
- mem_len=0 store of 0xAB to 0x4003 -> m_we=1, m_len=0, m_addr=0x4003, m_wdata=0xAB stable until m_ack, then mem_ack pulse.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: arbiter state encoding, memory length codes and helpers.
// Revision 1.0
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_GRANT_IF  = 2'd1,
    ST_GRANT_MEM = 2'd2,
    ST_DRAIN     = 2'd3
  } arb_state_e;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd3;

  localparam int STARVE_W = 3;

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] v,
                                                  input logic [STARVE_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between IF fetches and MEM loads/stores.
// Revision 1.0
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_L     = 32,
  parameter int DATA_L     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_re,
  input  logic [ADDR_L-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [DATA_L-1:0] if_rdata,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [ADDR_L-1:0] mem_addr,
  input  logic [1:0]        mem_len,
  input  logic [DATA_L-1:0] mem_wdata,
  output logic              mem_ack,
  output logic [DATA_L-1:0] mem_rdata,
  output logic              m_re,
  output logic              m_we,
  output logic [ADDR_L-1:0] m_addr,
  output logic [1:0]        m_len,
  output logic [DATA_L-1:0] m_wdata,
  input  logic              m_ack,
  input  logic [DATA_L-1:0] m_rdata
);

  localparam logic [STARVE_W-1:0] LIM = STARVE_W'(STARVE_LIM);

  arb_state_e          state_q;
  logic [STARVE_W-1:0] starve_q;
  logic                if_ack_q;
  logic [DATA_L-1:0]   if_rdata_q;
  logic                mem_ack_q;
  logic [DATA_L-1:0]   mem_rdata_q;
  logic                m_re_q;
  logic                m_we_q;
  logic [ADDR_L-1:0]   m_addr_q;
  logic [1:0]          m_len_q;
  logic [DATA_L-1:0]   m_wdata_q;

  // A requester still high in its own ack cycle must not be granted again.
  logic if_cand;
  logic mem_cand;
  logic if_wins;

  assign if_cand  = if_re && !if_flush && !if_ack_q;
  assign mem_cand = (mem_re || mem_we) && !mem_ack_q;
  assign if_wins  = if_cand && (starve_q == LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      if_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      mem_ack_q   <= 1'b0;
      mem_rdata_q <= '0;
      m_re_q      <= 1'b0;
      m_we_q      <= 1'b0;
      m_addr_q    <= '0;
      m_len_q     <= '0;
      m_wdata_q   <= '0;
    end else begin
      if_ack_q  <= 1'b0;
      mem_ack_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!if_re) starve_q <= '0;
          if (mem_cand && !if_wins) begin
            state_q   <= ST_GRANT_MEM;
            m_we_q    <= mem_we;
            m_re_q    <= !mem_we;
            m_addr_q  <= mem_addr;
            m_len_q   <= mem_len;
            m_wdata_q <= mem_wdata;
            if (if_re) starve_q <= sat_inc(starve_q, LIM);
          end else if (if_cand) begin
            state_q   <= ST_GRANT_IF;
            m_re_q    <= 1'b1;
            m_we_q    <= 1'b0;
            m_addr_q  <= if_addr;
            m_len_q   <= LEN_W;
            m_wdata_q <= '0;
            starve_q  <= '0;
          end
        end
        ST_GRANT_IF: begin
          if (m_ack) begin
            m_re_q  <= 1'b0;
            state_q <= ST_IDLE;
            // A flush coinciding with completion discards the fetched word.
            if (!if_flush) begin
              if_rdata_q <= m_rdata;
              if_ack_q   <= 1'b1;
            end
          end else if (if_flush) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_GRANT_MEM: begin
          if (m_ack) begin
            m_re_q    <= 1'b0;
            m_we_q    <= 1'b0;
            mem_ack_q <= 1'b1;
            state_q   <= ST_IDLE;
            if (m_re_q) mem_rdata_q <= m_rdata;
          end
        end
        ST_DRAIN: begin
          if (m_ack) begin
            m_re_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mem_ack   = mem_ack_q;
  assign mem_rdata = mem_rdata_q;
  assign m_re      = m_re_q;
  assign m_we      = m_we_q;
  assign m_addr    = m_addr_q;
  assign m_len     = m_len_q;
  assign m_wdata   = m_wdata_q;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst && mem_re && mem_we)
      $warning("mem_port_arbiter: mem_re and mem_we both high, treated as a write");
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors plus multi-cycle sequences for the memory port arbiter.
// Revision 1.0
`default_nettype none

module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_re = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_re = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [1:0]  mem_len = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        m_re;
  logic        m_we;
  logic [31:0] m_addr;
  logic [1:0]  m_len;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;

  int pass_cnt = 0;
  int total_cnt = 0;
  int lat = 1;
  int mcnt;

  mem_port_arbiter #(.ADDR_L(32), .DATA_L(32), .STARVE_LIM(4)) dut (
    .clk(clk), .rst(rst),
    .if_re(if_re), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .m_re(m_re), .m_we(m_we), .m_addr(m_addr), .m_len(m_len), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: acks lat cycles after the strobe rises, aborts on rst.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ack   <= 1'b0;
      mcnt    <= 0;
      m_rdata <= 32'hDEADBEEF;
    end else begin
      m_ack   <= 1'b0;
      m_rdata <= 32'hDEADBEEF;
      if ((m_re || m_we) && !m_ack) begin
        if (mcnt + 1 >= lat) begin
          m_ack   <= 1'b1;
          mcnt    <= 0;
          m_rdata <= (m_addr == 32'h1000) ? 32'h0000_0013 : (m_addr ^ 32'h5A5A_0000);
        end else begin
          mcnt <= mcnt + 1;
        end
      end
    end
  end

  // Grant log: {we, addr} recorded at each strobe rising edge.
  logic [32:0] glog[$];
  logic        prev_strobe = 1'b0;
  always @(negedge clk) begin
    if ((m_re || m_we) && !prev_strobe) glog.push_back({m_we, m_addr});
    prev_strobe = m_re || m_we;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic do_txn(input logic is_if, input logic we, input logic [31:0] addr,
                        input logic [1:0] len, input logic [31:0] wdata, input int l,
                        output int cyc, output logic [35:0] f, output logic [31:0] wd,
                        output logic stable, output logic [31:0] rd, output logic pulse_ok);
    logic seen;
    logic got;
    lat = l;
    if (is_if) begin
      if_re = 1'b1; if_addr = addr;
    end else begin
      mem_re = !we; mem_we = we; mem_addr = addr; mem_len = len; mem_wdata = wdata;
    end
    cyc = 0; seen = 1'b0; got = 1'b0; stable = 1'b1; f = '0; wd = '0; rd = '0;
    while (!got && cyc < 40) begin
      step();
      cyc++;
      if (m_re || m_we) begin
        if (!seen) begin
          f = {m_we, m_re, m_len, m_addr}; wd = m_wdata; seen = 1'b1;
        end else if ({m_we, m_re, m_len, m_addr} !== f || m_wdata !== wd) begin
          stable = 1'b0;
        end
      end
      if (is_if ? if_ack : mem_ack) begin
        got = 1'b1;
        rd = is_if ? if_rdata : mem_rdata;
      end
    end
    if (!got) cyc = -1;
    if_re = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
    step();
    pulse_ok = !(if_ack || mem_ack) && !(m_re || m_we);
    step(); step();
  endtask

  typedef struct {
    logic        is_if;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    int          lat;
    int          exp_cyc;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[6];

  initial begin
    int          cyc;
    logic [35:0] f;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        stable;
    logic        pulse_ok;
    logic        any_ack;
    int          mem_i;
    logic        if_done;
    logic        mem_done;
    logic        if_seen;

    vt[0] = '{1'b1, 1'b0, 32'h0000_1000, LEN_W, 32'h0,  1, 3, 32'h0000_0013};
    vt[1] = '{1'b0, 1'b0, 32'h0000_2000, LEN_W, 32'h0,  1, 3, 32'h5A5A_2000};
    vt[2] = '{1'b0, 1'b0, 32'h0000_2004, LEN_H, 32'h0,  3, 5, 32'h5A5A_2004};
    vt[3] = '{1'b0, 1'b1, 32'h0000_4003, LEN_B, 32'hAB, 2, 4, 32'h0};
    vt[4] = '{1'b1, 1'b0, 32'h0000_3000, LEN_W, 32'h0,  4, 6, 32'h5A5A_3000};
    vt[5] = '{1'b0, 1'b1, 32'h0000_4010, LEN_H, 32'h1234, 1, 3, 32'h0};

    // Reset state
    step(); step();
    chk("rst_outs", |{if_ack, if_rdata, mem_ack, mem_rdata, m_re, m_we, m_addr, m_len, m_wdata}, 0);
    chk("rst_state", dut.state_q, ST_IDLE);
    chk("rst_starve", dut.starve_q, 0);
    rst = 1'b0;
    step();
    chk("idle_no_strobe", {m_re, m_we}, 0);

    // Table-driven single transactions
    for (int i = 0; i < 6; i++) begin
      do_txn(vt[i].is_if, vt[i].we, vt[i].addr, vt[i].len, vt[i].wdata, vt[i].lat,
             cyc, f, wd, stable, rd, pulse_ok);
      chk($sformatf("v%0d_latency", i), cyc, vt[i].exp_cyc);
      chk($sformatf("v%0d_fields", i), f,
          {vt[i].we, !vt[i].we, vt[i].is_if ? LEN_W : vt[i].len, vt[i].addr});
      chk($sformatf("v%0d_stable", i), stable, 1);
      if (vt[i].we) chk($sformatf("v%0d_wdata", i), wd, vt[i].wdata);
      else          chk($sformatf("v%0d_rdata", i), rd, vt[i].exp_rdata);
      chk($sformatf("v%0d_pulse_no_regrant", i), pulse_ok, 1);
    end

    // IF and MEM together: MEM first, IF at the end of mem_ack's cycle
    lat = 1;
    if_re = 1'b1; if_addr = 32'h1000;
    mem_re = 1'b1; mem_addr = 32'h2000; mem_len = LEN_W;
    step();
    chk("both_first_mem", {m_re, m_addr}, {1'b1, 32'h2000});
    step(); step();
    chk("both_mem_ack", {mem_ack, mem_rdata}, {1'b1, 32'h5A5A_2000});
    mem_re = 1'b0;
    step();
    chk("both_then_if", {m_re, m_addr, if_ack}, {1'b1, 32'h1000, 1'b0});
    step(); step();
    chk("both_if_ack", {if_ack, if_rdata}, {1'b1, 32'h0000_0013});
    if_re = 1'b0;
    step(); step(); step();

    // Starvation: IF stays requested; flush pulses in each mem_ack cycle hide IF there
    glog.delete();
    lat = 1;
    if_re = 1'b1; if_addr = 32'h1000;
    mem_we = 1'b1; mem_addr = 32'h5000; mem_len = LEN_W; mem_wdata = 32'h0;
    mem_i = 0; if_done = 1'b0; mem_done = 1'b0; if_seen = 1'b0;
    for (int c = 0; c < 300 && !(if_done && mem_done); c++) begin
      step();
      if_flush = 1'b0;
      if (m_re && m_addr == 32'h1000 && !if_seen) begin
        if_seen = 1'b1;
        chk("starve_cleared_on_if", dut.starve_q, 0);
      end
      if (if_ack) begin
        if_re = 1'b0; if_done = 1'b1;
      end
      if (mem_ack) begin
        mem_i++;
        if (mem_i == 4) chk("starve_at_limit", dut.starve_q, 4);
        if (mem_i == 10) begin
          mem_we = 1'b0; mem_done = 1'b1;
        end else begin
          mem_addr = 32'h5000 + 32'(4 * mem_i); mem_wdata = 32'(mem_i);
          if (if_re) if_flush = 1'b1;
        end
      end
    end
    if_re = 1'b0; mem_we = 1'b0; if_flush = 1'b0;
    step(); step();
    chk("starve_completed", {if_done, mem_done}, 2'b11);
    chk("starve_grant_count", glog.size(), 11);
    chk("starve_if_after_4", (glog.size() > 4) ? glog[4] : 33'h0, {1'b0, 32'h1000});
    chk("starve_grant_3_mem", (glog.size() > 4) ? glog[3] : 33'h0, {1'b1, 32'h500C});
    chk("starve_final", dut.starve_q, 0);

    // Flush during GRANT_IF with latency 5: DRAIN holds strobe, no if_ack
    lat = 5; any_ack = 1'b0;
    if_re = 1'b1; if_addr = 32'h1000;
    step(); any_ack |= if_ack;
    step(); any_ack |= if_ack;
    if_flush = 1'b1; if_re = 1'b0;
    step(); any_ack |= if_ack;
    if_flush = 1'b0;
    chk("drain_state", dut.state_q, ST_DRAIN);
    step(); step(); any_ack |= if_ack;
    chk("drain_strobe_held", {m_re, m_addr}, {1'b1, 32'h1000});
    step(); any_ack |= if_ack;
    chk("drain_m_ack", {m_ack, m_re}, 2'b11);
    step(); any_ack |= if_ack;
    chk("drain_strobe_drop", {m_re, dut.state_q}, {1'b0, ST_IDLE});
    step(); any_ack |= if_ack;
    step(); any_ack |= if_ack;
    chk("drain_no_if_ack", any_ack, 0);
    do_txn(1'b1, 1'b0, 32'h3000, LEN_W, 32'h0, 1, cyc, f, wd, stable, rd, pulse_ok);
    chk("post_drain_latency", cyc, 3);
    chk("post_drain_rdata", rd, 32'h5A5A_3000);

    // Flush coinciding with m_ack: result discarded, straight to IDLE
    lat = 2; any_ack = 1'b0;
    if_re = 1'b1; if_addr = 32'h1000;
    step(); step(); step(); any_ack |= if_ack;
    chk("flush_ack_same_m_ack", m_ack, 1);
    if_flush = 1'b1; if_re = 1'b0;
    step(); any_ack |= if_ack;
    if_flush = 1'b0;
    chk("flush_ack_idle", {dut.state_q, m_re}, {ST_IDLE, 1'b0});
    step(); any_ack |= if_ack;
    step(); any_ack |= if_ack;
    chk("flush_ack_no_if_ack", any_ack, 0);

    // Reset in the middle of GRANT_MEM
    lat = 8; any_ack = 1'b0;
    mem_re = 1'b1; mem_addr = 32'h2000; mem_len = LEN_W;
    step(); step();
    chk("rst_mid_granted", {dut.state_q, m_re}, {ST_GRANT_MEM, 1'b1});
    rst = 1'b1; mem_re = 1'b0;
    #1;
    chk("rst_mid_outs", |{if_ack, if_rdata, mem_ack, mem_rdata, m_re, m_we, m_addr, m_len, m_wdata}, 0);
    chk("rst_mid_state", dut.state_q, ST_IDLE);
    step();
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      any_ack |= if_ack | mem_ack | m_re | m_we;
    end
    chk("rst_mid_quiet", any_ack, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
